// File: rtl/neuro_ev_pkg.sv
// Shared event-path definitions for the neuromorphic core's transmit and receive sides.
// Timestamping is selected by defining SPIKE_TX_TS_EN.
package neuro_ev_pkg;

`ifdef SPIKE_TX_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    localparam int unsigned N_SRC_DEF = 16;
    localparam int unsigned TS_W_DEF  = 16;

    typedef struct packed {
        logic [TS_W_DEF-1:0]          ts;
        logic [$clog2(N_SRC_DEF)-1:0] id;
    } ev_word_t;

    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned ev_w(input int unsigned n, input int unsigned ts_w,
                                         input bit ts_en);
        return ts_en ? (ts_w + id_w(n)) : id_w(n);
    endfunction

    // Saturating add clamped to the largest value representable in w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] cur, input logic [63:0] inc,
                                            input int unsigned w);
        logic [63:0] max_val;
        logic [63:0] sum;
        max_val = (64'd1 << w) - 64'd1;
        sum     = cur + inc;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr, wrapping.
// N must be a power of two so the search index wraps by truncation.
module rr_arbiter
    import neuro_ev_pkg::*;
#(
    parameter  int unsigned N = 16,
    localparam int unsigned W = id_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_id,
    output logic         any
);

    logic [W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = W'(ptr + k);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/spike_event_tx.sv
// Spike-to-event producer: per-source pending flags, round-robin selection, valid/ready output.
// Define SPIKE_TX_TS_EN to prepend a free-running timestamp to each event word.
module spike_event_tx
    import neuro_ev_pkg::*;
#(
    parameter  int unsigned N_SRC  = 16,
    parameter  int unsigned TS_W   = 16,
    parameter  int unsigned DROP_W = 8,
    localparam int unsigned ID_W   = id_w(N_SRC),
    localparam int unsigned EV_W   = ev_w(N_SRC, TS_W, TS_EN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [N_SRC-1:0]  spike_i,
    output logic              ev_valid_o,
    input  logic              ev_ready_i,
    output logic [EV_W-1:0]   ev_data_o,
    output logic [N_SRC-1:0]  pending_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    input  logic              drop_clr_i
);

    logic [N_SRC-1:0] grant;
    logic [N_SRC-1:0] grant_eff;
    logic [N_SRC-1:0] lost;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W:0]    drops;
    logic             any;
    logic             slot_free;
    logic             load;
`ifdef SPIKE_TX_TS_EN
    logic [TS_W-1:0]  ts_cnt;
`endif

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req      (pending_o),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    assign slot_free = !ev_valid_o || ev_ready_i;
    assign load      = slot_free && enable_i && any;
    assign grant_eff = {N_SRC{load}} & grant;
    // A spike on the source being granted this edge re-arms it rather than counting as lost.
    assign lost      = spike_i & pending_o & ~grant_eff;

    always_comb begin
        drops = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            drops = drops + {{ID_W{1'b0}}, lost[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_valid_o <= 1'b0;
            ev_data_o  <= '0;
            pending_o  <= '0;
            drop_cnt_o <= '0;
            rr_ptr     <= '0;
`ifdef SPIKE_TX_TS_EN
            ts_cnt     <= '0;
`endif
        end else begin
            pending_o <= spike_i | (pending_o & ~grant_eff);

            if (drop_clr_i) begin
                drop_cnt_o <= '0;
            end else begin
                drop_cnt_o <= DROP_W'(sat_add(64'(drop_cnt_o), 64'(drops), DROP_W));
            end

            if (load) begin
                ev_valid_o <= 1'b1;
`ifdef SPIKE_TX_TS_EN
                ev_data_o  <= {ts_cnt, grant_id};
`else
                ev_data_o  <= grant_id;
`endif
                rr_ptr     <= grant_id + ID_W'(1);
            end else if (slot_free) begin
                ev_valid_o <= 1'b0;
            end

`ifdef SPIKE_TX_TS_EN
            if (enable_i) begin
                ts_cnt <= ts_cnt + TS_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_spike_event_tx.sv
// Self-checking bench for spike_event_tx against a behavioural event-queue model.
// Timestamp scenarios run only when SPIKE_TX_TS_EN is defined.
module tb_spike_event_tx;

    localparam int N        = 16;
    localparam int ID_W     = 4;
    localparam int DROP_MAX = 255;
`ifdef SPIKE_TX_TS_EN
    localparam int EV_W = 20;
`else
    localparam int EV_W = 4;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            enable_i;
    logic [N-1:0]    spike_i;
    logic            ev_valid_o;
    logic            ev_ready_i;
    logic [EV_W-1:0] ev_data_o;
    logic [N-1:0]    pending_o;
    logic [7:0]      drop_cnt_o;
    logic            drop_clr_i;

    int checks = 0;
    int passed = 0;

    spike_event_tx #(.N_SRC(16), .TS_W(16), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable_i),
        .spike_i    (spike_i),
        .ev_valid_o (ev_valid_o),
        .ev_ready_i (ev_ready_i),
        .ev_data_o  (ev_data_o),
        .pending_o  (pending_o),
        .drop_cnt_o (drop_cnt_o),
        .drop_clr_i (drop_clr_i)
    );

    always #5 clk = ~clk;

    // Behavioural model: a set of waiting sources, a held output event, and counters.
    bit m_pend[N];
    bit m_valid;
    int m_id, m_ev_ts, m_ptr, m_drop, m_ts;

    function automatic void model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0; m_id = 0; m_ev_ts = 0; m_ptr = 0; m_drop = 0; m_ts = 0;
    endfunction

    function automatic void model_edge();
        int  win   = -1;
        int  lostn = 0;
        bit  free  = !m_valid || ev_ready_i;
        if (free && enable_i) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (win < 0 && m_pend[j]) win = j;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (spike_i[i] && m_pend[i] && i != win) lostn++;
            m_pend[i] = spike_i[i] || (m_pend[i] && i != win);
        end
        if (win >= 0) begin
            m_valid = 1'b1; m_id = win; m_ev_ts = m_ts; m_ptr = (win + 1) % N;
        end else if (free) begin
            m_valid = 1'b0;
        end
        if (drop_clr_i) m_drop = 0;
        else m_drop = (m_drop + lostn > DROP_MAX) ? DROP_MAX : m_drop + lostn;
`ifdef SPIKE_TX_TS_EN
        if (enable_i) m_ts = (m_ts + 1) % 65536;
`endif
    endfunction

    function automatic logic [N-1:0] m_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [EV_W-1:0] m_data();
`ifdef SPIKE_TX_TS_EN
        return {16'(m_ev_ts), 4'(m_id)};
`else
        return 4'(m_id);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; enable_i = 1'b0; spike_i = '0; ev_ready_i = 1'b0; drop_clr_i = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ev_valid_o, pending_o, drop_cnt_o} !== {1'b0, 16'h0, 8'h0})
            $display("FAIL reset_state got valid=%b pend=%h drop=%0d exp 0/0000/0",
                     ev_valid_o, pending_o, drop_cnt_o);
        else passed++;
        checks++;
        if (ev_data_o !== '0) $display("FAIL reset_data got %h exp 0", ev_data_o);
        else passed++;
    endtask

    task automatic test_single();
        apply_reset();
        enable_i = 1'b1; ev_ready_i = 1'b1; spike_i = 16'h0008;
        step();
        spike_i = '0;
        checks++;
        if ({ev_valid_o, pending_o} !== {1'b0, 16'h0008})
            $display("FAIL single_pend got valid=%b pend=%h exp 0/0008", ev_valid_o, pending_o);
        else passed++;
        step();
        checks++;
        if ({ev_valid_o, ev_data_o[ID_W-1:0], pending_o} !== {1'b1, 4'd3, 16'h0})
            $display("FAIL single_event got valid=%b id=%0d pend=%h exp 1/3/0000",
                     ev_valid_o, ev_data_o[ID_W-1:0], pending_o);
        else passed++;
        step();
        checks++;
        if (ev_valid_o !== 1'b0) $display("FAIL single_one_cycle got valid=%b exp 0", ev_valid_o);
        else passed++;
    endtask

    task automatic test_rr_backpressure();
        int              got[$];
        logic [EV_W-1:0] held;
        bit              hold_prev = 1'b0;
        apply_reset();
        enable_i = 1'b1; spike_i = 16'hFFFF;
        step();
        spike_i = '0;
        for (int c = 0; c < 80 && got.size() < 16; c++) begin
            ev_ready_i = c[0];
            if (hold_prev) begin
                checks++;
                if (ev_data_o !== held) $display("FAIL rr_hold_stable got %h exp %h", ev_data_o, held);
                else passed++;
            end
            if (ev_valid_o && ev_ready_i) got.push_back(int'(ev_data_o[ID_W-1:0]));
            hold_prev = ev_valid_o && !ev_ready_i;
            held = ev_data_o;
            step();
            checks++;
            if ({ev_valid_o, pending_o, drop_cnt_o} !== {m_valid, m_pend_vec(), 8'(m_drop)} ||
                (m_valid && ev_data_o !== m_data()))
                $display("FAIL rr_model got %b/%h/%0d/%h exp %b/%h/%0d/%h", ev_valid_o, pending_o,
                         drop_cnt_o, ev_data_o, m_valid, m_pend_vec(), m_drop, m_data());
            else passed++;
        end
        checks++;
        if (got.size() != 16) $display("FAIL rr_count got %0d events exp 16", got.size());
        else passed++;
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] != i) $display("FAIL rr_order[%0d] got %0d exp %0d", i, got[i], i);
            else passed++;
        end
        checks++;
        if (drop_cnt_o !== 8'd0) $display("FAIL rr_no_drop got %0d exp 0", drop_cnt_o);
        else passed++;
    endtask

    task automatic test_fairness();
        int got[$];
        int exp_seq[6] = '{0, 5, 0, 5, 0, 5};
        apply_reset();
        enable_i = 1'b1; ev_ready_i = 1'b1; spike_i = 16'h0021;
        for (int c = 0; c < 20; c++) begin
            if (ev_valid_o && ev_ready_i) got.push_back(int'(ev_data_o[ID_W-1:0]));
            step();
            checks++;
            if ({ev_valid_o, pending_o, drop_cnt_o} !== {m_valid, m_pend_vec(), 8'(m_drop)} ||
                (m_valid && ev_data_o !== m_data()))
                $display("FAIL fair_model got %b/%h/%0d/%h exp %b/%h/%0d/%h", ev_valid_o, pending_o,
                         drop_cnt_o, ev_data_o, m_valid, m_pend_vec(), m_drop, m_data());
            else passed++;
        end
        spike_i = '0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got.size() || got[i] != exp_seq[i])
                $display("FAIL fair_seq[%0d] got %0d exp %0d", i,
                         (i < got.size()) ? got[i] : -1, exp_seq[i]);
            else passed++;
        end
    endtask

    task automatic test_drops();
        apply_reset();
        enable_i = 1'b1; ev_ready_i = 1'b0; spike_i = 16'h0080;
        for (int c = 0; c < 300; c++) begin
            step();
            checks++;
            if ({ev_valid_o, pending_o, drop_cnt_o} !== {m_valid, m_pend_vec(), 8'(m_drop)} ||
                (m_valid && ev_data_o !== m_data()))
                $display("FAIL drop_model got %b/%h/%0d/%h exp %b/%h/%0d/%h", ev_valid_o, pending_o,
                         drop_cnt_o, ev_data_o, m_valid, m_pend_vec(), m_drop, m_data());
            else passed++;
        end
        checks++;
        if (drop_cnt_o !== 8'd255) $display("FAIL drop_saturate got %0d exp 255", drop_cnt_o);
        else passed++;
        drop_clr_i = 1'b1;
        step();
        drop_clr_i = 1'b0;
        checks++;
        if (drop_cnt_o !== 8'd0) $display("FAIL drop_clear got %0d exp 0", drop_cnt_o);
        else passed++;
        spike_i = '0;
    endtask

    task automatic test_collision();
        apply_reset();
        enable_i = 1'b1; ev_ready_i = 1'b1; spike_i = 16'h0004;
        step();
        step();
        spike_i = '0;
        checks++;
        if ({ev_valid_o, ev_data_o[ID_W-1:0], pending_o[2], drop_cnt_o} !== {1'b1, 4'd2, 1'b1, 8'd0})
            $display("FAIL collide_first got valid=%b id=%0d pend2=%b drop=%0d exp 1/2/1/0",
                     ev_valid_o, ev_data_o[ID_W-1:0], pending_o[2], drop_cnt_o);
        else passed++;
        step();
        checks++;
        if ({ev_valid_o, ev_data_o[ID_W-1:0], pending_o, drop_cnt_o} !== {1'b1, 4'd2, 16'h0, 8'd0})
            $display("FAIL collide_second got valid=%b id=%0d pend=%h drop=%0d exp 1/2/0000/0",
                     ev_valid_o, ev_data_o[ID_W-1:0], pending_o, drop_cnt_o);
        else passed++;
        step();
        checks++;
        if (ev_valid_o !== 1'b0) $display("FAIL collide_idle got valid=%b exp 0", ev_valid_o);
        else passed++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            spike_i    = N'($urandom & $urandom & $urandom);
            ev_ready_i = ($urandom_range(0, 3) != 0);
            enable_i   = ($urandom_range(0, 7) != 0);
            drop_clr_i = ($urandom_range(0, 63) == 0);
            rst        = (c == 700);
            step();
            checks++;
            if ({ev_valid_o, pending_o, drop_cnt_o} !== {m_valid, m_pend_vec(), 8'(m_drop)} ||
                (m_valid && ev_data_o !== m_data()))
                $display("FAIL rand_model c=%0d got %b/%h/%0d/%h exp %b/%h/%0d/%h", c, ev_valid_o,
                         pending_o, drop_cnt_o, ev_data_o, m_valid, m_pend_vec(), m_drop, m_data());
            else passed++;
        end
        rst = 1'b0; spike_i = '0; drop_clr_i = 1'b0;
    endtask

`ifdef SPIKE_TX_TS_EN
    task automatic test_timestamp();
        int              ts_seen[$];
        logic [EV_W-1:0] held;
        apply_reset();
        enable_i = 1'b1; ev_ready_i = 1'b1;
        for (int c = 0; c < 25; c++) begin
            spike_i = (c == 0 || c == 10) ? 16'h0002 : 16'h0;
            if (ev_valid_o && ev_ready_i) ts_seen.push_back(int'(ev_data_o[EV_W-1:ID_W]));
            step();
        end
        checks++;
        if (ts_seen.size() != 2 || ts_seen[1] - ts_seen[0] != 10)
            $display("FAIL ts_delta got n=%0d delta=%0d exp 2/10", ts_seen.size(),
                     (ts_seen.size() == 2) ? ts_seen[1] - ts_seen[0] : -1);
        else passed++;

        ev_ready_i = 1'b0; spike_i = 16'h0001;
        step();
        spike_i = '0;
        step();
        held = ev_data_o;
        enable_i = 1'b0; spike_i = 16'h0008;
        for (int c = 0; c < 5; c++) begin
            step();
            spike_i = '0;
            checks++;
            if ({ev_valid_o, ev_data_o, pending_o} !== {1'b1, held, 16'h0008})
                $display("FAIL ts_enable_hold got %b/%h/%h exp 1/%h/0008", ev_valid_o, ev_data_o,
                         pending_o, held);
            else passed++;
        end
        ev_ready_i = 1'b1;
        step();
        checks++;
        if (ev_valid_o !== 1'b0) $display("FAIL ts_enable_drain got valid=%b exp 0", ev_valid_o);
        else passed++;
        enable_i = 1'b1;
        step();
        checks++;
        if (ev_valid_o !== 1'b1 || ev_data_o !== m_data() ||
            ev_data_o[EV_W-1:ID_W] !== held[EV_W-1:ID_W] + 16'd1)
            $display("FAIL ts_freeze got %b/%h exp 1/%h", ev_valid_o, ev_data_o, m_data());
        else passed++;

        apply_reset();
        enable_i = 1'b1; ev_ready_i = 1'b1;
        while (m_ts != 16'hFFFE) step();
        spike_i = 16'h0003;
        step();
        spike_i = '0;
        step();
        checks++;
        if ({ev_valid_o, ev_data_o} !== {1'b1, 16'hFFFF, 4'd0})
            $display("FAIL ts_wrap_hi got %b/%h exp 1/ffff0", ev_valid_o, ev_data_o);
        else passed++;
        step();
        checks++;
        if ({ev_valid_o, ev_data_o} !== {1'b1, 16'h0000, 4'd1})
            $display("FAIL ts_wrap_lo got %b/%h exp 1/00001", ev_valid_o, ev_data_o);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1; enable_i = 1'b0; spike_i = '0; ev_ready_i = 1'b0; drop_clr_i = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rr_backpressure();
        test_fairness();
        test_drops();
        test_collision();
        test_random();
`ifdef SPIKE_TX_TS_EN
        test_timestamp();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
